// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: stage stall/branch/debug requests in,
// per-register hold vector, IF/ID squash, halt status and perf counters out.
interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             stallreq_id;
   logic             stallreq_ex;
   logic             stallreq_mem;
   logic             br;
   logic             halt_req;
   logic             resume_req;
   logic [5:0]       stall;
   logic             flush;
   logic             halted;
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Pipeline side: raises requests, consumes hold/squash/status.
   modport master (
      output stallreq_id, stallreq_ex, stallreq_mem, br, halt_req, resume_req,
      input  stall, flush, halted, cyc_cnt, stall_cnt, flush_cnt
   );

   // Controller side.
   modport slave (
      input  stallreq_id, stallreq_ex, stallreq_mem, br, halt_req, resume_req,
      output stall, flush, halted, cyc_cnt, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline controller: merges stage stall requests, squashes
// IF/ID on taken branches, sequences debug halt/drain/resume, counts events.
module pipe_ctrl #(
   parameter int CNT_W     = 32,
   parameter int DRAIN_CYC = 4
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave pif
);
   localparam int            DW         = $clog2(DRAIN_CYC + 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC);
   localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [5:0] req_v;
   logic [5:0] base_v;
   logic [5:0] stall;
   logic       flush;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic en);
      if (en && (v != {CNT_W{1'b1}}))
         return v + CNT_W'(1);
      return v;
   endfunction

   // Deeper stage wins: holding a later register must also hold all earlier ones.
   always_comb begin
      req_v = 6'b000000;
      if (pif.stallreq_mem)
         req_v = 6'b011111;
      else if (pif.stallreq_ex)
         req_v = 6'b001111;
      else if (pif.stallreq_id)
         req_v = 6'b000111;
   end

   // DRAIN freezes PC and IF/ID so older instructions retire behind bubbles.
   always_comb begin
      base_v = 6'b000000;
      case (state_q)
         ST_RUN:    base_v = 6'b000000;
         ST_DRAIN:  base_v = 6'b000011;
         ST_HALTED: base_v = 6'b111111;
         default:   base_v = 6'b000000;
      endcase
      stall = base_v | req_v;
      // A branch resolved under any stall request saw stale operands.
      flush = pif.br && (state_q == ST_RUN) && (req_v == 6'b000000);
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (pif.halt_req) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            // Only advancing cycles retire instructions toward WB.
            if (req_v == 6'b000000) begin
               if (drain_cnt_q <= DRAIN_ONE) begin
                  drain_cnt_d = '0;
                  state_d     = ST_HALTED;
               end else begin
                  drain_cnt_d = drain_cnt_q - DRAIN_ONE;
               end
            end
         end
         ST_HALTED: begin
            if (pif.resume_req)
               state_d = ST_RUN;
         end
         default: begin
            state_d     = ST_RUN;
            drain_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      cyc_cnt_d   = sat_inc(cyc_cnt_q, 1'b1);
      stall_cnt_d = sat_inc(stall_cnt_q, (state_q == ST_RUN) && stall[0]);
      flush_cnt_d = sat_inc(flush_cnt_q, flush);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= '0;
         cyc_cnt_q   <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         cyc_cnt_q   <= cyc_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign pif.stall     = stall;
   assign pif.flush     = flush;
   assign pif.halted    = (state_q == ST_HALTED);
   assign pif.cyc_cnt   = cyc_cnt_q;
   assign pif.stall_cnt = stall_cnt_q;
   assign pif.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expectations are queued when stimulus is
// driven and popped against DUT outputs once they have settled.
module tb_pipe_ctrl;
   logic clk;
   logic rst;
   logic rst4;

   pipe_ctrl_if #(.CNT_W(32)) pif ();
   pipe_ctrl_if #(.CNT_W(4))  pif4 ();

   pipe_ctrl #(.CNT_W(32), .DRAIN_CYC(4)) dut (
      .clk (clk),
      .rst (rst),
      .pif (pif.slave)
   );

   pipe_ctrl #(.CNT_W(4), .DRAIN_CYC(4)) dut4 (
      .clk (clk),
      .rst (rst4),
      .pif (pif4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic push(input string tag, input logic [31:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb.push_back(it);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      sb_item_t it;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
         return;
      end
      it = sb.pop_front();
      assert (obs === it.exp)
         $display("check %s observed=%0h", it.tag, obs);
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One pipeline cycle: drive inputs, check the combinational response,
   // then let the clock edge commit it.
   task automatic step(input string tag,
                       input logic id, input logic ex, input logic mem,
                       input logic b, input logic h, input logic r,
                       input logic [5:0] e_stall, input logic e_flush,
                       input logic e_halted);
      pif.stallreq_id  = id;
      pif.stallreq_ex  = ex;
      pif.stallreq_mem = mem;
      pif.br           = b;
      pif.halt_req     = h;
      pif.resume_req   = r;
      push({tag, ".stall"},  32'(e_stall));
      push({tag, ".flush"},  32'(e_flush));
      push({tag, ".halted"}, 32'(e_halted));
      #1;
      pop_chk(32'(pif.stall));
      pop_chk(32'(pif.flush));
      pop_chk(32'(pif.halted));
      tick();
   endtask

   task automatic chk_cnt(input string tag, input int e_cyc, input int e_stall,
                          input int e_flush);
      push({tag, ".cyc_cnt"},   32'(e_cyc));
      push({tag, ".stall_cnt"}, 32'(e_stall));
      push({tag, ".flush_cnt"}, 32'(e_flush));
      pop_chk(pif.cyc_cnt);
      pop_chk(pif.stall_cnt);
      pop_chk(pif.flush_cnt);
   endtask

   initial begin
      rst  = 1'b1;
      rst4 = 1'b1;
      pif.stallreq_id = 0; pif.stallreq_ex = 0; pif.stallreq_mem = 0;
      pif.br = 0; pif.halt_req = 0; pif.resume_req = 0;
      pif4.stallreq_id = 0; pif4.stallreq_ex = 0; pif4.stallreq_mem = 0;
      pif4.br = 0; pif4.halt_req = 0; pif4.resume_req = 0;

      tick();
      push("rst.stall", 32'h0);  pop_chk(32'(pif.stall));
      push("rst.halted", 32'h0); pop_chk(32'(pif.halted));
      chk_cnt("rst", 0, 0, 0);
      rst = 1'b0;

      // Priority merge and branch squash
      step("merge_all", 1, 1, 1, 0, 0, 0, 6'b011111, 0, 0);
      step("merge_ex",  1, 1, 0, 0, 0, 0, 6'b001111, 0, 0);
      step("merge_id",  1, 0, 0, 0, 0, 0, 6'b000111, 0, 0);
      step("br_clean",  0, 0, 0, 1, 0, 0, 6'b000000, 1, 0);
      chk_cnt("after_br", 4, 3, 1);
      step("br_stall",  1, 0, 0, 1, 0, 0, 6'b000111, 0, 0);

      // Plain halt: cycle 0 request, DRAIN cycles 1-4, halted from 5
      step("halt_c0",   0, 0, 0, 0, 1, 0, 6'b000000, 0, 0);
      step("drain_c1",  0, 0, 0, 1, 0, 0, 6'b000011, 0, 0);
      step("drain_c2",  0, 0, 0, 0, 0, 0, 6'b000011, 0, 0);
      step("drain_c3",  0, 0, 0, 0, 0, 0, 6'b000011, 0, 0);
      step("drain_c4",  0, 0, 0, 0, 0, 0, 6'b000011, 0, 0);
      step("halted_c5", 0, 0, 0, 1, 1, 0, 6'b111111, 0, 1);
      step("resume",    0, 0, 0, 0, 0, 1, 6'b111111, 0, 1);
      step("run_again", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
      chk_cnt("after_halt", 13, 4, 1);

      // Halt with a memory wait in cycle 2: halted slips to cycle 6
      step("halt2_c0",  0, 0, 0, 0, 1, 0, 6'b000000, 0, 0);
      step("drain2_c1", 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0);
      step("drain2_c2", 0, 0, 1, 0, 0, 0, 6'b011111, 0, 0);
      step("drain2_c3", 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0);
      step("drain2_c4", 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0);
      step("drain2_c5", 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0);
      step("halt2_c6",  0, 0, 0, 0, 0, 0, 6'b111111, 0, 1);

      // Conflicting debug requests
      step("hlt_both",  0, 0, 0, 0, 1, 1, 6'b111111, 0, 1);
      step("run_both",  0, 0, 0, 0, 1, 1, 6'b000000, 0, 0);
      step("drn_res1",  0, 0, 0, 0, 0, 1, 6'b000011, 0, 0);
      step("drn_res2",  0, 0, 0, 0, 0, 1, 6'b000011, 0, 0);
      step("drn_res3",  0, 0, 0, 0, 0, 1, 6'b000011, 0, 0);
      step("drn_res4",  0, 0, 0, 0, 0, 1, 6'b000011, 0, 0);
      step("hlt_res",   0, 0, 0, 0, 0, 1, 6'b111111, 0, 1);
      step("run_res",   0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);

      // Reset in the middle of a drain
      step("halt3_c0",  0, 0, 0, 0, 1, 0, 6'b000000, 0, 0);
      step("drain3_c1", 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0);
      rst = 1'b1;
      step("drain3_rst", 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0);
      rst = 1'b0;
      chk_cnt("post_rst", 0, 0, 0);
      step("post_rst",  0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);

      // Saturation on the 4-bit instance
      rst4 = 1'b0;
      pif4.stallreq_id = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      push("sat10.cyc_cnt", 32'd10);   pop_chk(32'(pif4.cyc_cnt));
      push("sat10.stall_cnt", 32'd10); pop_chk(32'(pif4.stall_cnt));
      for (int i = 0; i < 10; i++) tick();
      push("sat20.cyc_cnt", 32'd15);   pop_chk(32'(pif4.cyc_cnt));
      push("sat20.stall_cnt", 32'd15); pop_chk(32'(pif4.stall_cnt));
      push("sat20.flush_cnt", 32'd0);  pop_chk(32'(pif4.flush_cnt));
      pif4.stallreq_id = 1'b0;

      if (sb.size() != 0) begin
         errors++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the 5-stage RISC-V core. It merges stall requests from ID (load-use), EX (multi-cycle ops) and MEM (memory wait) into one per-register stall vector. It turns the ID-stage branch decision into an IF/ID squash and sequences debug halt/resume by draining in-flight instructions. It also keeps saturating performance counters.

## Interface
Parameters:
- `CNT_W`, 32: width of each performance counter.
- `DRAIN_CYC`, 4: number of advancing cycles needed to retire ID/EX through WB before the core is considered halted.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stallreq_id` input 1: load-use hazard request from ID.
- `stallreq_ex` input 1: multi-cycle operation busy in EX.
- `stallreq_mem` input 1: data memory not ready.
- `br` input 1: ID resolved a taken branch or jump this cycle.
- `halt_req` input 1: debug halt request, sampled as a level.
- `resume_req` input 1: debug resume request, sampled as a level.
- `stall` output 6: hold enables. Bit 0 is PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB. `stall[i]=1` with `stall[i+1]=0` inserts a bubble into register i+1.
- `flush` output 1: squash the IF/ID register, replacing the wrong-path fetch with a NOP.
- `halted` output 1: core fully drained and frozen.
- `cyc_cnt` output CNT_W: non-reset cycles.
- `stall_cnt` output CNT_W: RUN-state cycles with `stall[0]=1`.
- `flush_cnt` output CNT_W: cycles with `flush=1`.

## Operation
- The FSM has three states: RUN, DRAIN and HALTED. `drain_cnt` is a register of width clog2(DRAIN_CYC+1).
- The pipeline request vector `req_v` is the first match in this priority order:
  - `stallreq_mem` gives 6'b011111.
  - `stallreq_ex` gives 6'b001111.
  - `stallreq_id` gives 6'b000111.
  - Otherwise 6'b000000.
- The base vector depends on state: RUN gives 6'b000000, DRAIN gives 6'b000011, HALTED gives 6'b111111.
- `stall` = base vector OR `req_v`.
- `flush` = `br` AND state==RUN AND `req_v`==0.
  - A branch decided while any stall is requested uses invalid operands and is ignored.
  - In DRAIN or HALTED the ID instruction is not issued, so `br` is ignored.
- State transitions:
  - RUN: `halt_req`=1 moves to DRAIN and loads `drain_cnt`=DRAIN_CYC. `halt_req` has priority over a simultaneous `resume_req`.
  - DRAIN: when `req_v`==0, `drain_cnt` decrements. When it decrements from 1, the next state is HALTED. When `req_v`≠0, `drain_cnt` holds. `halt_req` and `resume_req` are ignored.
  - HALTED: `resume_req`=1 moves to RUN. `halt_req` is ignored.
- `halted` is 1 exactly when state==HALTED.
- Counters:
  - They increment on their condition and saturate at all-ones (no wrap).
  - `cyc_cnt` increments every cycle with `rst`=0.
  - `stall_cnt` increments only in RUN with `stall[0]`=1.
  - `flush_cnt` increments on `flush`=1.
  - They are cleared only by `rst`.

## Timing
- Reset values: state=RUN, `drain_cnt`=0, all counters 0. The outputs follow: `stall`=`req_v`, `halted`=0, and `flush` is determined by `br`/`req_v`.
- `rst` has priority over every other input in the same cycle.
- `stall` and `flush` are combinational from the inputs and the registered state, with zero-cycle latency to the pipeline registers.
- Halt latency with no stall requests:
  - `halt_req` is sampled at edge 0.
  - DRAIN covers cycles 1..DRAIN_CYC.
  - `halted`=1 from cycle DRAIN_CYC+1.
  - Each cycle with `req_v`≠0 during DRAIN extends this by one cycle.
- Resume: `resume_req` sampled in HALTED gives RUN and `stall`=`req_v` from the next cycle.
- Counters update at the clock edge; their values reflect the previous cycle's events.

## Test plan
- Priority merge: in RUN, drive `stallreq_id`=1, `stallreq_ex`=1, `stallreq_mem`=1 together. Required: `stall`=6'b011111. Dropping `stallreq_mem` gives 6'b001111; dropping `stallreq_ex` as well gives 6'b000111.
- Branch squash:
  - `br`=1 with no requests gives `flush`=1, and `flush_cnt` goes 0→1 on the next cycle.
  - `br`=1 with `stallreq_id`=1 gives `flush`=0 and `stall`=6'b000111.
- Halt/drain:
  - Pulse `halt_req` at cycle 0. Required: `stall`=6'b000011 in cycles 1-4, `halted`=1 and `stall`=6'b111111 from cycle 5.
  - Repeat with `stallreq_mem`=1 in cycle 2. Required: `stall`=6'b011111 in cycle 2 and `halted` from cycle 6.
- Resume and conflicts:
  - `halt_req` and `resume_req` high together in RUN enter DRAIN.
  - `resume_req` during DRAIN is ignored.
  - `resume_req` in HALTED returns to RUN with `stall`=0 next cycle; `br` in HALTED gives `flush`=0.
- Reset mid-drain: assert `rst` in cycle 2 of DRAIN. Required next cycle: state RUN, `halted`=0, `stall`=0, and all counters 0.
- Counter saturation: with CNT_W=4, hold `stallreq_id`=1 for 20 cycles. Required: `stall_cnt` and `cyc_cnt` stop at 15 and do not wrap.
